note_lane_vga: RTL and testbench

- Parametrised successor to the free-mode falling-note renderer.
- Keeps a per-lane scrolling history of note activity and renders it as vertical bars over a pitch-dependent gradient background.
- Sits between the keyboard/note decoder and the VGA pixel mux. Driven by the VGA pixel clock.
- Adds over the previous generation:
  - configurable lane count, geometry and history depth;
  - sticky note capture between scroll ticks;
  - pause and clear controls;
  - a registered pixel output.

---
 rtl/note_lane_vga.sv | 155 +++++++++++++++
 tb/tb_note_lane_vga.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_vga.sv
// note_lane_vga: per-lane scrolling note-history renderer for the VGA pixel pipe.
// Each lane keeps a HIST_DEPTH-row bit history. Newest data enters at the bottom
// row and moves up one row per scroll tick. The history is drawn as vertical bars
// over a pitch-dependent gradient, and the pixel leaves through one register stage.
// Optional feature macro: HIT_LINE_EN adds a two-row hit line just below the history.
// HIST_DEPTH must be at least 2.
module note_lane_vga #(
    parameter int unsigned NUM_LANES     = 7,
    parameter int unsigned LANE_X0       = 112,
    parameter int unsigned LANE_PITCH    = 64,
    parameter int unsigned LANE_WIDTH    = 32,
    parameter int unsigned HIST_DEPTH    = 384,
    parameter int unsigned SCROLL_PERIOD = 100000,
    parameter logic [23:0] BLOCK_COLOR   = 24'h000000
) (
    input  logic                 vga_clk,
    input  logic                 rst_n,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic [NUM_LANES-1:0] note,
    input  logic [1:0]           shift,
    input  logic                 pause,
    input  logic                 clear,
    output logic [23:0]          pos_data,
    output logic                 scroll_tick
);

    localparam int unsigned CNT_W  = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
    localparam int unsigned HIDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [23:0] HIT_IDLE_COLOR = 24'h808080;

    logic [CNT_W-1:0]     r_cnt;
    logic                 w_at_end;
    logic                 w_wrap;
    logic [31:0]          w_px;
    logic [31:0]          w_py;
    logic [HIDX_W-1:0]    w_row;
    logic [NUM_LANES-1:0] w_lane_hit;
    logic [NUM_LANES-1:0] w_lane_bar;
    logic                 w_any_hit;
    logic                 w_bar;
    logic                 w_in_hist;
    logic [7:0]           w_t;
    logic [23:0]          w_bg;
    logic [23:0]          w_pix;
    logic [23:0]          r_pos_data;
    logic                 r_tick;

    // A scroll step happens only on an unpaused, uncleared counter wrap
    assign w_at_end = (r_cnt == CNT_W'(SCROLL_PERIOD - 1));
    assign w_wrap   = w_at_end & ~pause & ~clear;

    // Scroll tick counter: clear restarts it, pause freezes it
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_W'(0);
        end else if (clear) begin
            r_cnt <= CNT_W'(0);
        end else if (!pause) begin
            if (w_at_end) begin
                r_cnt <= CNT_W'(0);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_px  = 32'(pos_x);
    assign w_py  = 32'(pos_y);
    assign w_row = HIDX_W'(pos_y);

`ifdef HIT_LINE_EN
    logic [NUM_LANES-1:0] w_lane_note;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam int unsigned BASE = LANE_X0 + g * LANE_PITCH;

        logic [HIST_DEPTH-1:0] r_lane_hist;
        logic                  r_cap;
        logic                  w_note_bit;

        // Lane 0 is the leftmost lane and is fed by the note MSB
        assign w_note_bit = note[NUM_LANES-1-g];

        // Sticky capture and history shift; clear outranks both
        always_ff @(posedge vga_clk or negedge rst_n) begin
            if (!rst_n) begin
                r_lane_hist <= '0;
                r_cap       <= 1'b0;
            end else if (clear) begin
                r_lane_hist <= '0;
                r_cap       <= 1'b0;
            end else if (w_wrap) begin
                r_lane_hist <= {r_cap | w_note_bit, r_lane_hist[HIST_DEPTH-1:1]};
                r_cap       <= 1'b0;
            end else begin
                r_cap <= r_cap | w_note_bit;
            end
        end

        // Unsigned column test: columns left of the lane never hit
        assign w_lane_hit[g] = (w_px >= BASE) && ((w_px - BASE) < LANE_WIDTH);
        assign w_lane_bar[g] = w_lane_hit[g] & r_lane_hist[w_row];
`ifdef HIT_LINE_EN
        assign w_lane_note[g] = w_lane_hit[g] & w_note_bit;
`endif
    end

    // At most one lane hits, so an OR-reduction gives the selected lane's data
    assign w_any_hit = |w_lane_hit;
    assign w_bar     = |w_lane_bar;
    assign w_in_hist = (w_py < HIST_DEPTH);

    // Gradient level: (y*2/3 - 1) in 11-bit arithmetic, low byte kept
    assign w_t = 8'(((11'(pos_y) << 1) / 11'd3) - 11'd1);

    // Background colour by pitch mode
    always_comb begin
        w_bg = 24'hFFFFFF;
        case (shift)
            2'b10:   w_bg = {w_t, w_t, 8'hFF};
            2'b01:   w_bg = {8'hFF, w_t, w_t};
            default: w_bg = 24'hFFFFFF;
        endcase
    end

    // Pixel select: bar over background, plus the optional hit line
    always_comb begin
        w_pix = w_bg;
        if (w_any_hit && w_in_hist && w_bar) begin
            w_pix = BLOCK_COLOR;
        end
`ifdef HIT_LINE_EN
        if (w_any_hit && ((w_py == HIST_DEPTH) || (w_py == HIST_DEPTH + 1))) begin
            w_pix = (|w_lane_note) ? BLOCK_COLOR : HIT_IDLE_COLOR;
        end
`endif
    end

    // Output register stage for pixel and tick pulse
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_data <= 24'h000000;
            r_tick     <= 1'b0;
        end else begin
            r_pos_data <= w_pix;
            r_tick     <= w_wrap;
        end
    end

    assign pos_data    = r_pos_data;
    assign scroll_tick = r_tick;

endmodule

// File: tb/tb_note_lane_vga.sv
// tb_note_lane_vga: directed test-plan sequence followed by randomized traffic,
// checked against a behavioural lane/history model.
module tb_note_lane_vga;

    localparam int NL    = 7;
    localparam int X0    = 112;
    localparam int PITCH = 64;
    localparam int WID   = 32;
    localparam int HD    = 384;
    localparam int SP    = 4;
    localparam logic [23:0] BLK = 24'h000000;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [6:0]  note;
    logic [1:0]  shift;
    logic        pause;
    logic        clear;
    logic [23:0] pos_data;
    logic        scroll_tick;

    always #5 vga_clk = ~vga_clk;

    note_lane_vga #(
        .NUM_LANES    (NL),
        .LANE_X0      (X0),
        .LANE_PITCH   (PITCH),
        .LANE_WIDTH   (WID),
        .HIST_DEPTH   (HD),
        .SCROLL_PERIOD(SP),
        .BLOCK_COLOR  (BLK)
    ) dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .note       (note),
        .shift      (shift),
        .pause      (pause),
        .clear      (clear),
        .pos_data   (pos_data),
        .scroll_tick(scroll_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: history as rows per lane, row 0 at the top of the screen
    bit m_hist [NL][HD];
    bit m_cap  [NL];
    int m_cnt  = 0;
    bit m_last_tick = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] m_pixel(input int x, input int y,
                                            input logic [6:0] nt, input logic [1:0] sh);
        logic [7:0]  t8;
        logic [23:0] bg;
        int off;
        int lane;
        t8 = 8'(((y * 2) / 3) - 1);
        if (sh == 2'b10)      bg = {t8, t8, 8'hFF};
        else if (sh == 2'b01) bg = {8'hFF, t8, t8};
        else                  bg = 24'hFFFFFF;
        if (x < X0) return bg;
        off  = x - X0;
        lane = off / PITCH;
        if (lane >= NL || (off % PITCH) >= WID) return bg;
        if (y < HD) return m_hist[lane][y] ? BLK : bg;
`ifdef HIT_LINE_EN
        if (y == HD || y == HD + 1) return nt[NL-1-lane] ? BLK : 24'h808080;
`endif
        return bg;
    endfunction

    // One clock: drive inputs, predict, check after the edge, advance the model
    task automatic step(input string tag, input int x, input int y, input logic [6:0] nt,
                        input logic [1:0] sh, input logic pz, input logic cl);
        logic [23:0] exp_pix;
        bit wrap;
        bit b;
        pos_x = 10'(x);
        pos_y = 10'(y);
        note  = nt;
        shift = sh;
        pause = pz;
        clear = cl;
        exp_pix = m_pixel(x, y, nt, sh);
        wrap = !cl && !pz && (m_cnt == SP - 1);
        @(posedge vga_clk);
        #1;
        check({tag, "_pix"}, 32'(pos_data), 32'(exp_pix));
        check({tag, "_tick"}, 32'(scroll_tick), 32'(wrap));
        m_last_tick = wrap;
        if (cl) begin
            for (int l = 0; l < NL; l++) begin
                m_cap[l] = 0;
                for (int r = 0; r < HD; r++) m_hist[l][r] = 0;
            end
            m_cnt = 0;
        end else begin
            if (!pz) m_cnt = (m_cnt + 1) % SP;
            for (int l = 0; l < NL; l++) begin
                b = m_cap[l] | nt[NL-1-l];
                if (wrap) begin
                    for (int r = 0; r < HD - 1; r++) m_hist[l][r] = m_hist[l][r+1];
                    m_hist[l][HD-1] = b;
                    m_cap[l] = 0;
                end else begin
                    m_cap[l] = b;
                end
            end
        end
        @(negedge vga_clk);
    endtask

    // Run unpaused idle cycles until a scroll step has just happened
    task automatic wait_tick(input string tag);
        int n = 0;
        while (!m_last_tick && n < 2 * SP) begin
            step(tag, 0, 0, 7'd0, 2'b00, 1'b0, 1'b0);
            n++;
        end
        if (!m_last_tick) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int x;
        int y;
        int sel;
        logic [6:0] nt;
        rst_n = 1'b0;
        pos_x = 10'd120;
        pos_y = 10'd0;
        note  = 7'd0;
        shift = 2'b00;
        pause = 1'b0;
        clear = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("rst_pix", 32'(pos_data), 32'h0);
        check("rst_tick", 32'(scroll_tick), 32'h0);
        rst_n = 1'b1;

        // Background and empty-history pixels
        step("bg_mid", 120, 0, 7'd0, 2'b00, 1'b0, 1'b0);
        check("bg_mid_c", 32'(pos_data), 32'hFFFFFF);
        step("bg_hi", 0, 300, 7'd0, 2'b10, 1'b0, 1'b0);
        check("bg_hi_c", 32'(pos_data), 32'hC7C7FF);
        step("bg_lo", 0, 0, 7'd0, 2'b01, 1'b0, 1'b0);
        check("bg_lo_c", 32'(pos_data), 32'hFFFFFF);
        step("bg_11", 500, 10, 7'd0, 2'b11, 1'b0, 1'b0);
        check("bg_11_c", 32'(pos_data), 32'hFFFFFF);

        // Short lane-0 pulse lands on the bottom row at the next tick
        step("pulse", 0, 0, 7'b1000000, 2'b00, 1'b0, 1'b0);
        wait_tick("w1");
        step("p383", 112, 383, 7'd0, 2'b00, 1'b1, 1'b0);
        check("bar383", 32'(pos_data), 32'h000000);
        step("p143", 143, 383, 7'd0, 2'b00, 1'b1, 1'b0);
        check("edge143", 32'(pos_data), 32'h000000);
        step("p144", 144, 383, 7'd0, 2'b00, 1'b1, 1'b0);
        check("edge144", 32'(pos_data), 32'hFFFFFF);
        step("p111", 111, 383, 7'd0, 2'b00, 1'b1, 1'b0);
        check("edge111", 32'(pos_data), 32'hFFFFFF);
        step("p384", 112, 384, 7'b1000000, 2'b00, 1'b1, 1'b0);
`ifdef HIT_LINE_EN
        check("row384", 32'(pos_data), 32'h000000);
`else
        check("row384", 32'(pos_data), 32'hFFFFFF);
`endif
        wait_tick("w2");
        step("p382", 112, 382, 7'd0, 2'b00, 1'b1, 1'b0);
        check("bar382", 32'(pos_data), 32'h000000);

        // Pause: no ticks, capture still accumulates
        for (int i = 0; i < 20; i++)
            step("pause", 176, 383, (i == 5) ? 7'b0100000 : 7'd0, 2'b00, 1'b1, 1'b0);
        wait_tick("w3");
        step("pz383", 176, 383, 7'd0, 2'b00, 1'b1, 1'b0);
        check("pz_bar", 32'(pos_data), 32'h000000);

        // Clear on the wrap cycle wins over the scroll step
        for (int i = 0; i < SP && m_cnt != SP - 1; i++)
            step("to_wrap", 0, 0, 7'd0, 2'b00, 1'b0, 1'b0);
        step("clr", 112, 381, 7'd0, 2'b00, 1'b0, 1'b1);
        step("clr_a", 112, 381, 7'd0, 2'b00, 1'b1, 1'b0);
        check("clr_a_c", 32'(pos_data), 32'hFFFFFF);
        step("clr_b", 176, 382, 7'd0, 2'b00, 1'b1, 1'b0);
        check("clr_b_c", 32'(pos_data), 32'hFFFFFF);
        for (int i = 0; i < SP + 1; i++)
            step("restart", 0, 0, 7'd0, 2'b00, 1'b0, 1'b0);

        // Randomized traffic focused on lane edges and the history boundary
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) x = int'($urandom_range(0, 1023));
            else x = X0 + int'($urandom_range(0, NL)) * PITCH
                     + ((sel == 1) ? -1 : (sel == 2) ? 0 : int'($urandom_range(WID - 1, WID)));
            sel = int'($urandom_range(0, 3));
            if (sel == 0) y = int'($urandom_range(0, 1023));
            else if (sel == 1) y = 0;
            else y = int'($urandom_range(HD - 12, HD + 4));
            nt = 7'($urandom) & 7'($urandom) & 7'($urandom);
            step("rnd", x, y, nt, 2'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
